// File: rtl/divider_n.sv
// Unsigned restoring divider, one quotient bit per cycle MSB first; result N cycles after accept (zero divisor: next cycle).
// Accepts only in IDLE; the result is held in DONE until out_ready, so the producer stalls on in_ready.
module divider_n #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [N-1:0]  partial;
  logic [N-1:0]  dvd;
  logic [N-1:0]  dvs;
  logic [N:0]    shifted;
  logic [N+1:0]  sum;
  logic          carry;
  logic          last;
  logic [N-1:0]  partial_nxt;
  logic [N-1:0]  dvd_nxt;
  logic          unused_sum;

  // Trial subtract as partial + ~divisor + 1; carry-out set means no borrow.
  // A successful trial is always below the divisor, so sum[N] is zero there.
  always_comb begin
    shifted     = {partial, dvd[N-1]};
    sum         = {1'b0, shifted} + {1'b0, ~{1'b0, dvs}} + (N+2)'(1);
    carry       = sum[N+1];
    partial_nxt = carry ? sum[N-1:0] : shifted[N-1:0];
    dvd_nxt     = {dvd[N-2:0], carry};
    last        = (cnt == CW'(N - 1));
  end

  assign unused_sum = sum[N];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = (divisor == '0) ? DONE : BUSY;
      BUSY: if (last) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // The dividend register doubles as the quotient accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      partial     <= '0;
      dvd         <= '0;
      dvs         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd     <= dividend;
            dvs     <= divisor;
            partial <= '0;
            cnt     <= '0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        BUSY: begin
          partial <= partial_nxt;
          dvd     <= dvd_nxt;
          cnt     <= cnt + CW'(1);
          if (last) begin
            quotient    <= dvd_nxt;
            remainder   <= partial_nxt;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

endmodule

// File: doc/divider_n.md
DIVIDER_N -- requirements
Module: divider_n

Interface
REQ-001: Parameter N, default 2; operand and result width in bits; legal for N >= 2.
REQ-002: clk  input  1  single clock; all state changes on rising edge.
REQ-003: rst_n  input  1  asynchronous, active-low reset.
REQ-004: in_valid  input  1  dividend/divisor valid.
REQ-005: in_ready  output  1  block can accept an operation.
REQ-006: dividend  input  N  unsigned dividend.
REQ-007: divisor  input  N  unsigned divisor.
REQ-008: out_valid  output  1  result registers valid.
REQ-009: out_ready  input  1  consumer accepts result.
REQ-010: quotient  output  N  unsigned quotient.
REQ-011: remainder  output  N  unsigned remainder.
REQ-012: div_by_zero  output  1  result came from a zero divisor.

Function
REQ-013: The block SHALL implement unsigned restoring division, one quotient bit per cycle, MSB first.
REQ-014: States SHALL be IDLE, BUSY and DONE.
REQ-015: in_ready SHALL be 1 exactly when state is IDLE; out_valid SHALL be 1 exactly when state is DONE.
REQ-016: Acceptance edge = rising edge with in_valid=1 and in_ready=1; dividend and divisor SHALL be captured on that edge only; inputs at other times SHALL be ignored.
REQ-017: On acceptance with divisor != 0: IDLE->BUSY; partial remainder cleared; iteration counter = 0.
REQ-018: Each BUSY edge: shift next dividend bit into an (N+1)-bit partial remainder; trial = partial - divisor; if no borrow, partial = trial and quotient bit = 1, else partial is kept and quotient bit = 0.
REQ-019: Trial subtraction SHALL be computed as a two's-complement add (partial + ~divisor with carry-in 1) over N+1 bits; borrow = NOT carry-out.
REQ-020: After exactly N BUSY edges, BUSY->DONE; out_valid is first visible N cycles after the acceptance edge.
REQ-021: On acceptance with divisor == 0: IDLE->DONE on the acceptance edge (out_valid visible 1 cycle later); quotient = all ones; remainder = dividend; div_by_zero = 1.
REQ-022: div_by_zero SHALL be 0 for every nonzero-divisor result.
REQ-023: quotient, remainder and div_by_zero SHALL be registered and held stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-024: DONE with out_ready=1 on an edge SHALL go to DONE->IDLE; the earliest next acceptance is the following edge.
REQ-025: out_ready SHALL be ignored outside DONE; in_valid SHALL be ignored outside IDLE.
REQ-026: Results SHALL satisfy dividend = quotient*divisor + remainder and remainder < divisor for all nonzero divisors, including dividend=0 and divisor > dividend.
REQ-027: No combinational path SHALL exist from any input to any output.

Reset
REQ-028: rst_n=0 SHALL immediately, independent of clk, force state IDLE with quotient=0, remainder=0, div_by_zero=0, out_valid=0, in_ready=1, and counter and partial remainder = 0.
REQ-029: Reset asserted in BUSY or DONE SHALL abort the operation; no result for it SHALL ever be presented.
REQ-030: The first acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Verification (N=8)
REQ-031: dividend=100, divisor=7 accepted -> out_valid high 8 cycles later; quotient=14, remainder=2, div_by_zero=0.
REQ-032: dividend=5, divisor=0 -> out_valid high 1 cycle later; quotient=0xFF, remainder=5, div_by_zero=1.
REQ-033: 255/1 -> quotient=255, remainder=0; 3/10 -> quotient=0, remainder=3; 0/9 -> quotient=0, remainder=0.
REQ-034: 200/13 with out_ready=0 for 5 cycles after out_valid -> quotient=15 and remainder=5 held; in_ready=0 throughout; IDLE entered on the edge where out_ready=1.
REQ-035: rst_n pulsed low mid-BUSY (cycle 4 of 100/7) -> outputs zero at once, out_valid never asserts; then 9/3 -> quotient=3, remainder=0.
REQ-036: Randomized back-to-back operations checked against a reference model, with random in_valid/out_ready gaps -> every result matches REQ-026; none dropped or duplicated.
